// File: rtl/bitn_logic_seq.sv
// rtl/bitn_logic_seq.sv - lane-serial AND/OR/XOR/NOR unit with valid/ready handshakes
//
// Computes op(a, b) over WIDTH-bit operands, LANE bits per clock. Operands are
// captured on acceptance in IDLE. Lanes are produced low to high during BUSY.
// The result is held in DONE until the consumer takes it.
//
// Build option: define LOGIC_PARITY_EN to add the parity output, the XOR-reduction of z.
//
// Parameters:
//   WIDTH  operand/result width (WIDTH % LANE must be 0)
//   LANE   bits processed per clock (LANE == WIDTH gives a single BUSY cycle)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake, carrying op/a/b
//   op                  00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b                operands
//   out_valid/out_ready result handshake, carrying z/zero (and parity)
//   z, zero             result register and its all-zero flag
//   parity              XOR-reduction of z (LOGIC_PARITY_EN only)
//   busy                high in BUSY or DONE

module bitn_logic_seq #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
`ifdef LOGIC_PARITY_EN
  output logic             parity,
`endif
  output logic             busy
);

  localparam int NLANES = WIDTH / LANE;
  localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    lane_cnt;
  logic             zero_acc;
  logic [LANE-1:0]  lane_a;
  logic [LANE-1:0]  lane_b;
  logic [LANE-1:0]  lane_res;
  logic             last_lane;
  logic             accept;

`ifdef LOGIC_PARITY_EN
  logic             par_acc;
`endif

  assign accept    = (state == S_IDLE) && in_valid;
  assign last_lane = (lane_cnt == CW'(NLANES - 1));

  // The lane slice is taken from the captured operands only, so input changes
  // after acceptance cannot reach the result.
  assign lane_a = a_q[lane_cnt*LANE +: LANE];
  assign lane_b = b_q[lane_cnt*LANE +: LANE];

  always_comb begin
    lane_res = '0;
    case (op_q)
      2'b00:   lane_res = lane_a & lane_b;
      2'b01:   lane_res = lane_a | lane_b;
      2'b10:   lane_res = lane_a ^ lane_b;
      default: lane_res = ~(lane_a | lane_b);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
      S_BUSY:  if (last_lane) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_BUSY) || (state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      lane_cnt <= '0;
      zero_acc <= 1'b0;
      z        <= '0;
      zero     <= 1'b0;
`ifdef LOGIC_PARITY_EN
      par_acc  <= 1'b0;
      parity   <= 1'b0;
`endif
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      op_q     <= op;
      lane_cnt <= '0;
      zero_acc <= 1'b1;
`ifdef LOGIC_PARITY_EN
      par_acc  <= 1'b0;
`endif
    end else if (state == S_BUSY) begin
      z[lane_cnt*LANE +: LANE] <= lane_res;
      lane_cnt <= lane_cnt + CW'(1);
      zero_acc <= zero_acc & (lane_res == '0);
`ifdef LOGIC_PARITY_EN
      par_acc  <= par_acc ^ (^lane_res);
`endif
      // The flags fold in the final lane directly, because the accumulators
      // only see it one edge later.
      if (last_lane) begin
        zero   <= zero_acc & (lane_res == '0);
`ifdef LOGIC_PARITY_EN
        parity <= par_acc ^ (^lane_res);
`endif
      end
    end
  end

endmodule
